// File: rtl/muldiv_ctrl.sv
// -----------------------------------------------------------------------------
// muldiv_ctrl
// HI/LO multiply/divide unit controller for a pipelined MIPS-style core.
// The arithmetic result is computed combinationally when the operation is
// accepted and held in pending registers. A down-counter then models the
// unit latency, and HI/LO are committed on the final busy cycle.
//
// Ports
//   clk        in   1   clock, all state updates on posedge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   E-stage request valid this cycle
//   op         in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 no-op
//   a          in  32   rs operand / MTHI-MTLO data
//   b          in  32   rt operand
//   md_use_D   in   1   D-stage instruction touches the mul/div unit
//   busy       out  1   arithmetic operation in progress (registered)
//   stall      out  1   freeze PC/D, flush E
//   hi         out 32   HI register
//   lo         out 32   LO register
//
// State table
//   state | meaning
//   IDLE  | ready; accepts arithmetic ops and MTHI/MTLO
//   RUN   | arithmetic op counting down; start is ignored
// -----------------------------------------------------------------------------
module muldiv_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_D,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        is_arith;
    logic        is_signed;
    logic        is_div;
    logic [63:0] prod;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] den;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign is_arith  = ~op[2];
    assign is_signed = ~op[0];
    assign is_div    = op[1];

    // Sign-extending to 64 bits makes the low 64 bits of an unsigned multiply
    // equal to the two's-complement signed product.
    always_comb begin
        prod = '0;
        if (is_signed) begin
            prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        end else begin
            prod = {32'd0, a} * {32'd0, b};
        end
    end

    // Signed division via magnitudes: quotient negated when signs differ,
    // remainder takes the sign of the dividend. 0x80000000 / -1 falls out as
    // 0x80000000 with remainder 0 without special casing.
    always_comb begin
        a_mag = (is_signed && a[31]) ? (32'd0 - a) : a;
        b_mag = (is_signed && b[31]) ? (32'd0 - b) : b;
        den   = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / den;
        r_mag = a_mag % den;
        quot  = (is_signed && (a[31] ^ b[31])) ? (32'd0 - q_mag) : q_mag;
        rem   = (is_signed && a[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_arith) begin
                        state_d = RUN;
                        if (is_div) begin
                            cnt_d = 4'(DIV_CYCLES);
                            if (b == 32'd0) begin
                                // Divide by zero still runs full latency but
                                // commits the current HI/LO back unchanged.
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = rem;
                                pend_lo_d = quot;
                            end
                        end else begin
                            cnt_d     = 4'(MULT_CYCLES);
                            pend_hi_d = prod[63:32];
                            pend_lo_d = prod[31:0];
                        end
                    end else if (op == 3'd4) begin
                        hi_d = a;
                    end else if (op == 3'd5) begin
                        lo_d = a;
                    end
                end
            end
            RUN: begin
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy  = (state_q == RUN);
    assign stall = md_use_D & (busy | (start & is_arith));
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule
